ysyx_22040175_dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port: the slave end of the request/response interface that the MEM stage initiates.
- Accepts one request at a time over a valid/ready handshake.
- Performs a byte-masked 64-bit write or a 64-bit read on an internal word array, then returns a response after a programmable latency.
- Sits between the pipeline's memory stage and the simulation top; replaces zero-latency DPI memory so that pipeline stall logic can be exercised.

---
 rtl/ysyx_22040175_dmem_responder_if.sv | 26 ++
 rtl/ysyx_22040175_dmem_responder.sv | 118 +++++++++++
 tb/tb_ysyx_22040175_dmem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040175_dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory responder (slave).
//   req_*: one request, valid/ready handshake, byte-masked 64-bit write or read
//   rsp_*: one response, valid/ready handshake, read data plus range error
interface ysyx_22040175_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22040175_dmem_responder.sv
// Memory-side responder for the core's load/store port. Holds a 2^DEPTH_LOG2
// x 64-bit array; accepts one request at a time, commits writes on the accept
// edge and returns a response LATENCY edges after accept (accept edge counted).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of the request/response interface
//   busy   - high whenever the FSM is not IDLE
module ysyx_22040175_dmem_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  ysyx_22040175_dmem_responder_if.slave      bus,
  output logic                               busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HI    = DEPTH_LOG2 + 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  cap_wen;
  logic                  cap_in_range;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [63:0]           mem [DEPTH];

  logic                  accept;
  logic                  req_in_range;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  unused_addr_lsb;

  assign accept          = bus.req_valid & bus.req_ready;
  assign req_in_range    = (bus.req_addr[31:HI] == BASE_ADDR[31:HI]);
  assign req_idx         = bus.req_addr[HI-1:3];
  assign unused_addr_lsb = ^bus.req_addr[2:0];

  // Write commits on the accept edge itself, so a later read in any
  // subsequent transaction sees it regardless of LATENCY.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wen && req_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.req_wmask[i]) mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_wen       <= 1'b0;
      cap_in_range  <= 1'b0;
      cap_idx       <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            cap_wen       <= bus.req_wen;
            cap_in_range  <= req_in_range;
            cap_idx       <= req_idx;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (LATENCY == 1) begin
              // Response sampled on the accept edge: use the live request.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= ~req_in_range;
              bus.rsp_rdata <= (!bus.req_wen && req_in_range) ? mem[req_idx] : 64'd0;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state         <= RESP;
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ~cap_in_range;
            bus.rsp_rdata <= (!cap_wen && cap_in_range) ? mem[cap_idx] : 64'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // No accept on the release edge: req_ready rises only afterwards.
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040175_dmem_responder.sv
module tb_ysyx_22040175_dmem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT_A = 2;
  localparam logic [31:0] SPAN = 32'h0000_8000;  // 4096 words * 8 bytes

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_22040175_dmem_responder_if ifa();
  ysyx_22040175_dmem_responder_if ifb();

  ysyx_22040175_dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .busy(busy_a));

  ysyx_22040175_dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(BASE), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .busy(busy_b));

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          hold;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction on dut_a; returns response and edge count from
  // accept (inclusive) to the first cycle rsp_valid is seen.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                     input logic [7:0] wm, input int hold,
                     output logic [63:0] rd, output logic err, output int lat);
    int guard;
    rd = '0; err = 1'b0; lat = 0;
    guard = 0;
    @(negedge clk);
    while (!ifa.req_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("req_ready_wait", 128'(ifa.req_ready), 128'(1'b1));
    ifa.req_wen = wen; ifa.req_addr = addr; ifa.req_wdata = wd; ifa.req_wmask = wm;
    ifa.req_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    // Scramble the operands after accept; they must not matter.
    ifa.req_valid = 1'b0;
    ifa.req_wen = ~wen; ifa.req_addr = $urandom; ifa.req_wdata = {$urandom, $urandom};
    ifa.req_wmask = 8'hFF;
    @(negedge clk);
    guard = 0;
    while (!ifa.rsp_valid && guard < 40) begin
      @(posedge clk); lat++; @(negedge clk); guard++;
    end
    chk("rsp_valid_wait", 128'(ifa.rsp_valid), 128'(1'b1));
    rd = ifa.rsp_rdata; err = ifa.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_hold", {ifa.rsp_valid, ifa.req_ready, busy_a, ifa.rsp_err, ifa.rsp_rdata},
          {1'b1, 1'b0, 1'b1, err, rd});
    end
    ifa.rsp_ready = 1'b1;
    @(posedge clk);
    #1 ifa.rsp_ready = 1'b0;
    chk("rsp_release", {ifa.rsp_valid, ifa.req_ready, busy_a, ifa.rsp_err, ifa.rsp_rdata},
        {1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
  endtask

  vec_t        tbl[9];
  logic [63:0] rd;
  logic        err;
  int          lat;
  logic [63:0] model [16];
  int          idx_list [16];
  logic [63:0] bdata;

  initial begin
    tbl[0] = '{1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0, 1'b0};
    tbl[1] = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 5, 64'h1122_3344_5566_7788, 1'b0};
    tbl[2] = '{1'b1, 32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 64'd0, 1'b0};
    tbl[3] = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_AAAA, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1, 64'd0, 1'b1};
    tbl[5] = '{1'b1, 32'h0000_0010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 64'd0, 1'b1};
    tbl[6] = '{1'b0, 32'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_AAAA, 1'b0};
    tbl[7] = '{1'b0, 32'h9000_0000, 64'd0, 8'h00, 2, 64'd0, 1'b1};
    tbl[8] = '{1'b0, 32'h8000_0017, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_AAAA, 1'b0};

    ifa.req_valid = 0; ifa.req_wen = 0; ifa.req_addr = 0; ifa.req_wdata = 0;
    ifa.req_wmask = 0; ifa.rsp_ready = 0;
    ifb.req_valid = 0; ifb.req_wen = 0; ifb.req_addr = 0; ifb.req_wdata = 0;
    ifb.req_wmask = 0; ifb.rsp_ready = 0;

    // Reset state
    #12;
    chk("reset_a", {ifa.req_ready, ifa.rsp_valid, ifa.rsp_err, busy_a, ifa.rsp_rdata},
        {4'b0000, 64'd0});
    chk("reset_b", {ifb.req_ready, ifb.rsp_valid, ifb.rsp_err, busy_b, ifb.rsp_rdata},
        {4'b0000, 64'd0});
    @(negedge clk); rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].hold, rd, err, lat);
      chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(LAT_A));
      chk($sformatf("tbl%0d_rsp", i), {err, rd}, {tbl[i].exp_err, tbl[i].exp_rdata});
    end

    // Reset while a read is waiting
    @(negedge clk);
    ifa.req_wen = 0; ifa.req_addr = 32'h8000_0010; ifa.req_valid = 1'b1;
    @(posedge clk);
    #1 ifa.req_valid = 1'b0;
    chk("wait_busy", 128'(busy_a), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {ifa.rsp_valid, busy_a, ifa.req_ready}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_ready", 128'(ifa.req_ready), 128'(1'b1));
    txn(1'b0, 32'h8000_0010, 64'd0, 8'h00, 0, rd, err, lat);
    chk("rst_mid_read", {err, rd}, {1'b0, 64'h1122_3344_AAAA_AAAA});

    // LATENCY=1, back-to-back with req_valid held high
    bdata = 64'h0123_4567_89AB_CDEF;
    begin
      int guard = 0;
      @(negedge clk);
      while (!ifb.req_ready && guard < 20) begin @(negedge clk); guard++; end
      chk("b_ready_wait", 128'(ifb.req_ready), 128'(1'b1));
    end
    ifb.req_wen = 1'b1; ifb.req_addr = 32'h8000_0008; ifb.req_wdata = bdata;
    ifb.req_wmask = 8'hFF; ifb.req_valid = 1'b1; ifb.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      // Accept on even edges, one-cycle response right after each.
      chk($sformatf("b2b_%0d", k), {ifb.rsp_valid, ifb.req_ready, ifb.rsp_err},
          {(k % 2 == 0), (k % 2 == 1), 1'b0});
    end
    ifb.req_wen = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b_read", {ifb.rsp_valid, ifb.rsp_err, ifb.rsp_rdata}, {2'b10, bdata});
    ifb.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b_idle", {ifb.rsp_valid, ifb.req_ready, busy_b}, 3'b010);
    ifb.rsp_ready = 1'b0;

    // Randomized against a word-array model
    for (int k = 0; k < 16; k++) begin
      idx_list[k] = (k * 251 + 5) % 4096;
      model[k] = {$urandom, $urandom};
      txn(1'b1, BASE + 32'(idx_list[k] * 8), model[k], 8'hFF, 0, rd, err, lat);
      chk("init_wr", {err, rd}, {1'b0, 64'd0});
    end
    for (int n = 0; n < 60; n++) begin
      logic        wen, inr;
      logic [31:0] addr;
      logic [63:0] wd, exp;
      logic [7:0]  wm;
      int          k;
      wen = 1'($urandom);
      wd  = {$urandom, $urandom};
      wm  = 8'($urandom);
      k   = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) begin
        addr = $urandom;
        if (addr >= BASE && addr < BASE + SPAN) addr = addr ^ 32'h4000_0000;
      end else begin
        addr = BASE + 32'(idx_list[k] * 8) + 32'($urandom_range(0, 7));
      end
      inr = (addr >= BASE) && (addr < BASE + SPAN);
      txn(wen, addr, wd, wm, $urandom_range(0, 2), rd, err, lat);
      exp = (!wen && inr) ? model[k] : 64'd0;
      if (wen && inr) begin
        for (int b = 0; b < 8; b++) if (wm[b]) model[k][8*b +: 8] = wd[8*b +: 8];
      end
      chk($sformatf("rnd%0d", n), {err, rd}, {~inr, exp});
      chk($sformatf("rnd%0d_lat", n), 128'(lat), 128'(LAT_A));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
